// File: rtl/wb_regfile.sv
// Writeback-stage register file: 32 x 32-bit, r0 hardwired to zero, two
// combinational read ports with same-cycle write bypass, plus commit
// statistics (write count, last destination, last data).
module wb_regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegW_enable_W,
  input  logic        Result_src_W,
  input  logic [31:0] ALU_result_W,
  input  logic [31:0] mem_read_W,
  input  logic [4:0]  RDadd_W,
  input  logic [4:0]  rs1_addr,
  input  logic [4:0]  rs2_addr,
  output logic [31:0] rs1_data,
  output logic [31:0] rs2_data,
  output logic [31:0] result_W,
  output logic [31:0] wr_count,
  output logic [4:0]  last_rd,
  output logic [31:0] last_data
);

  logic [31:0] regs_q [32];
  logic [31:0] wr_count_q;
  logic [4:0]  last_rd_q;
  logic [31:0] last_data_q;
  logic        commit;

  // Writeback mux and commit qualification; writes to r0 are dropped.
  always_comb begin
    result_W = Result_src_W ? mem_read_W : ALU_result_W;
    commit   = RegW_enable_W && (RDadd_W != 5'd0);
  end

  // Array and statistics update; reset has priority so nothing commits while rst is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= '0;
      end
      wr_count_q  <= '0;
      last_rd_q   <= '0;
      last_data_q <= '0;
    end else if (commit) begin
      regs_q[RDadd_W] <= result_W;
      wr_count_q      <= wr_count_q + 32'd1;
      last_rd_q       <= RDadd_W;
      last_data_q     <= result_W;
    end
  end

  // Read ports: r0 reads zero, then same-cycle bypass of the pending write, then the array.
  always_comb begin
    rs1_data = regs_q[rs1_addr];
    if (rs1_addr == 5'd0) begin
      rs1_data = '0;
    end else if (RegW_enable_W && (RDadd_W == rs1_addr)) begin
      rs1_data = result_W;
    end

    rs2_data = regs_q[rs2_addr];
    if (rs2_addr == 5'd0) begin
      rs2_data = '0;
    end else if (RegW_enable_W && (RDadd_W == rs2_addr)) begin
      rs2_data = result_W;
    end
  end

  // Statistics outputs.
  always_comb begin
    wr_count  = wr_count_q;
    last_rd   = last_rd_q;
    last_data = last_data_q;
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: a reference model produces expected values,
// which are queued when stimulus is driven and popped when outputs are sampled.
module tb_wb_regfile;

  logic        clk;
  logic        rst;
  logic        RegW_enable_W;
  logic        Result_src_W;
  logic [31:0] ALU_result_W;
  logic [31:0] mem_read_W;
  logic [4:0]  RDadd_W;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [31:0] result_W;
  logic [31:0] wr_count;
  logic [4:0]  last_rd;
  logic [31:0] last_data;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_q [$];
  string       tag_q [$];

  // Reference model state.
  logic [31:0] m_regs [32];
  logic [31:0] m_count;
  logic [4:0]  m_last_rd;
  logic [31:0] m_last_data;

  wb_regfile dut (
    .clk          (clk),
    .rst          (rst),
    .RegW_enable_W(RegW_enable_W),
    .Result_src_W (Result_src_W),
    .ALU_result_W (ALU_result_W),
    .mem_read_W   (mem_read_W),
    .RDadd_W      (RDadd_W),
    .rs1_addr     (rs1_addr),
    .rs2_addr     (rs2_addr),
    .rs1_data     (rs1_data),
    .rs2_data     (rs2_data),
    .result_W     (result_W),
    .wr_count     (wr_count),
    .last_rd      (last_rd),
    .last_data    (last_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] m_result();
    return Result_src_W ? mem_read_W : ALU_result_W;
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] addr);
    if (addr == 5'd0) return 32'd0;
    if (RegW_enable_W && RDadd_W == addr) return m_result();
    return m_regs[addr];
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    m_count     = '0;
    m_last_rd   = '0;
    m_last_data = '0;
  endtask

  task automatic push(input string tag, input logic [31:0] v);
    tag_q.push_back(tag);
    exp_q.push_back(v);
  endtask

  task automatic pop_check(input logic [31:0] obs);
    logic [31:0] e;
    string       t;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_empty observed=%h expected=none", obs);
      return;
    end
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    total++;
    assert (obs === e) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", t, obs, e);
    end
  endtask

  // Rising edge: model commits the same way a write would, then sample 1ns later.
  task automatic edge_step();
    @(posedge clk);
    if (!rst && RegW_enable_W && RDadd_W != 5'd0) begin
      m_regs[RDadd_W] = m_result();
      m_count         = m_count + 32'd1;
      m_last_rd       = RDadd_W;
      m_last_data     = m_result();
    end
    #1;
  endtask

  task automatic drive(input logic en, input logic src, input logic [4:0] rd,
                       input logic [31:0] alu, input logic [31:0] mem);
    @(negedge clk);
    RegW_enable_W = en;
    Result_src_W  = src;
    RDadd_W       = rd;
    ALU_result_W  = alu;
    mem_read_W    = mem;
  endtask

  task automatic check_stats(input string tag);
    push({tag, "_count"}, m_count);
    pop_check(wr_count);
    push({tag, "_last_rd"}, {27'd0, m_last_rd});
    pop_check({27'd0, last_rd});
    push({tag, "_last_data"}, m_last_data);
    pop_check(last_data);
  endtask

  task automatic check_read(input string tag, input logic [4:0] a1, input logic [4:0] a2);
    rs1_addr = a1;
    rs2_addr = a2;
    push({tag, "_rs1"}, m_read(a1));
    push({tag, "_rs2"}, m_read(a2));
    #1;
    pop_check(rs1_data);
    pop_check(rs2_data);
  endtask

  initial begin
    rst = 1'b0;
    RegW_enable_W = 1'b0;
    Result_src_W  = 1'b0;
    ALU_result_W  = '0;
    mem_read_W    = '0;
    RDadd_W       = '0;
    rs1_addr      = '0;
    rs2_addr      = '0;
    m_reset();
    #2 rst = 1'b1;

    // Reset: every address reads zero.
    @(negedge clk);
    for (int a = 0; a < 32; a++) begin
      check_read("rst_read", 5'(a), 5'(31 - a));
    end
    check_stats("rst");

    // Bypass stays live in reset, but the edge must not commit.
    drive(1'b1, 1'b0, 5'd4, 32'h0000_0077, 32'h0);
    check_read("rst_bypass", 5'd4, 5'd3);
    edge_step();
    RegW_enable_W = 1'b0;
    check_read("rst_nocommit", 5'd4, 5'd4);
    check_stats("rst_nocommit");

    @(negedge clk);
    rst = 1'b0;

    // Plain ALU write to r5.
    drive(1'b1, 1'b0, 5'd5, 32'h1234_5678, 32'hXXXX_XXXX);
    push("alu_result_W", 32'h1234_5678);
    #1 pop_check(result_W);
    edge_step();
    RegW_enable_W = 1'b0;
    check_read("r5", 5'd5, 5'd0);
    check_stats("r5");

    // Load write to r7 with same-cycle bypass on both ports; ALU input is X.
    drive(1'b1, 1'b1, 5'd7, 32'hXXXX_XXXX, 32'hDEAD_BEEF);
    push("load_result_W", 32'hDEAD_BEEF);
    #1 pop_check(result_W);
    check_read("r7_bypass", 5'd7, 5'd7);
    check_read("r7_mixed", 5'd7, 5'd5);
    edge_step();
    RegW_enable_W = 1'b0;
    check_read("r7", 5'd7, 5'd5);
    check_stats("r7");

    // Write to r0 is dropped.
    drive(1'b1, 1'b0, 5'd0, 32'hFFFF_FFFF, 32'hXXXX_XXXX);
    check_read("r0_pre", 5'd0, 5'd7);
    edge_step();
    RegW_enable_W = 1'b0;
    check_read("r0_post", 5'd0, 5'd0);
    check_stats("r0");

    // Back-to-back writes to r3: later value wins.
    drive(1'b1, 1'b0, 5'd3, 32'h0000_000A, 32'h0);
    edge_step();
    drive(1'b1, 1'b1, 5'd3, 32'h0, 32'h0000_000B);
    check_read("r3_bypass", 5'd3, 5'd2);
    edge_step();
    RegW_enable_W = 1'b0;
    check_read("r3", 5'd3, 5'd7);
    check_stats("r3");

    // Write r9, then assert reset mid-cycle: clears immediately.
    drive(1'b1, 1'b0, 5'd9, 32'h0000_0055, 32'h0);
    edge_step();
    RegW_enable_W = 1'b0;
    check_read("r9", 5'd9, 5'd3);
    #1 rst = 1'b1;
    m_reset();
    check_read("mid_rst", 5'd9, 5'd5);
    check_stats("mid_rst");
    @(negedge clk);
    rst = 1'b0;

    // First write after reset release commits normally.
    drive(1'b1, 1'b0, 5'd10, 32'h0000_0099, 32'h0);
    edge_step();
    RegW_enable_W = 1'b0;
    check_read("r10", 5'd10, 5'd9);
    check_stats("r10");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog.
  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/wb_regfile.md
WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 SHALL have port clk, input, 1, clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1, reset, asynchronous, active-high.
REQ-003 SHALL have port RegW_enable_W, input, 1, writeback-stage register write enable.
REQ-004 SHALL have port Result_src_W, input, 1, result select: 1 = load data, 0 = ALU result.
REQ-005 SHALL have port ALU_result_W, input, 32, ALU result from the MEM/WB pipeline register.
REQ-006 SHALL have port mem_read_W, input, 32, load data from the MEM/WB pipeline register.
REQ-007 SHALL have port RDadd_W, input, 5, destination register address.
REQ-008 SHALL have ports rs1_addr and rs2_addr, input, 5 each, decode-stage read addresses.
REQ-009 SHALL have ports rs1_data and rs2_data, output, 32 each, read data.
REQ-010 SHALL have port result_W, output, 32, selected writeback value, for forwarding to execute.
REQ-011 SHALL have port wr_count, output, 32, number of committed register writes.
REQ-012 SHALL have port last_rd, output, 5, destination of the most recent committed write.
REQ-013 SHALL have port last_data, output, 32, data of the most recent committed write.

Function
REQ-014 SHALL drive result_W combinationally: mem_read_W when Result_src_W=1, else ALU_result_W.
REQ-015 SHALL hold 32 x 32-bit registers; register 0 SHALL always read 0 and SHALL never be written.
REQ-016 SHALL commit result_W into register RDadd_W on a rising clk when RegW_enable_W=1 and RDadd_W!=0 (a "commit").
REQ-017 SHALL treat RegW_enable_W=1 with RDadd_W=0 as no commit: array, wr_count, last_rd and last_data unchanged.
REQ-018 SHALL read both ports combinationally, with zero-cycle latency from address to data.
REQ-019 Read-port priority: addr=0 -> 0; else RegW_enable_W=1 and RDadd_W=addr -> result_W (write-before-read bypass in the same cycle); else array contents.
REQ-020 SHALL apply the bypass to rs1 and rs2 independently; both SHALL bypass when both match RDadd_W.
REQ-021 SHALL increment wr_count by 1 on each commit, modulo 2^32 (0xFFFFFFFF + 1 -> 0x00000000).
REQ-022 SHALL on each commit load last_rd <= RDadd_W and last_data <= result_W, registered, visible the cycle after the commit edge.
REQ-023 SHALL commit back-to-back writes to the same register on consecutive cycles; the later value SHALL win.
REQ-024 SHALL ignore X on mem_read_W when Result_src_W=0, and X on ALU_result_W when Result_src_W=1.

Reset
REQ-025 SHALL on rst=1 asynchronously clear all 32 registers, wr_count, last_rd and last_data to 0.
REQ-026 SHALL commit nothing while rst=1, including a write whose edge coincides with rst assertion.
REQ-027 SHALL keep result_W and bypass paths combinational during reset; rs1_data/rs2_data SHALL return the cleared array (0) unless the bypass condition holds.
REQ-028 SHALL resume commits on the first rising clk after rst deasserts.

Verification
REQ-029 Reset then read all 32 addresses -> every rs1_data and rs2_data = 0; wr_count=0.
REQ-030 Enable=1, RDadd=5, Result_src=0, ALU=0x12345678 for one cycle, then read r5 -> 0x12345678; wr_count=1; last_rd=5; last_data=0x12345678.
REQ-031 Same cycle: enable=1, RDadd=7, Result_src=1, mem_read=0xDEADBEEF, rs1_addr=rs2_addr=7 -> both ports = 0xDEADBEEF before the edge.
REQ-032 Enable=1, RDadd=0, ALU=0xFFFFFFFF -> r0 reads 0; wr_count, last_rd and last_data unchanged.
REQ-033 Write r3=0xA then r3=0xB on consecutive cycles -> r3 = 0xB; wr_count increments by 2.
REQ-034 Write r9=0x55, then assert rst mid-run -> r9=0 and wr_count=0 immediately; a write on the next cycle after deassert commits normally.
